// File: rtl/fir_sample_reader.sv
// Buffers 16-bit FIR output samples in a small FIFO and presents them one byte
// at a time (high byte first) on an 8-bit port. Optional macro FIR_RD_OVF_EN adds a sticky overflow flag.
module fir_sample_reader #(
  parameter int DEPTH = 4,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [15:0]  y_in,
  input  logic                y_valid,
  input  logic                rd_next,
`ifdef FIR_RD_OVF_EN
  input  logic                ovf_clr,
  output logic                ovf,
`endif
  output logic [7:0]          data_out,
  output logic                byte_valid,
  output logic                byte_is_hi,
  output logic [LVL_W-1:0]    level,
  output logic                full
);

  localparam int DATA_W = 16;
  localparam int PTR_W  = $clog2(DEPTH);

  typedef enum logic [1:0] {EMPTY, SHOW_HI, SHOW_LO} state_t;

  state_t                    state, state_nxt;
  logic signed [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]          wptr, rptr, rptr_inc;
  logic [LVL_W-1:0]          level_nxt;
  logic                      push, pop, drop;
  logic [7:0]                dout_nxt;
  logic                      vld_nxt, hi_nxt;

  function automatic logic [7:0] hi_byte(input logic signed [DATA_W-1:0] w);
    return w[15:8];
  endfunction

  function automatic logic [7:0] lo_byte(input logic signed [DATA_W-1:0] w);
    return w[7:0];
  endfunction

  // The head word leaves only when its low byte is consumed. A push into a full
  // FIFO is allowed only alongside that pop, so it lands on the departing slot.
  always_comb begin
    pop      = (state == SHOW_LO) && rd_next;
    push     = y_valid && ((level != LVL_W'(DEPTH)) || pop);
    drop     = y_valid && !push;
    rptr_inc = rptr + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  // Presentation decisions are based on the occupancy before this edge.
  always_comb begin
    state_nxt = state;
    dout_nxt  = data_out;
    vld_nxt   = byte_valid;
    hi_nxt    = byte_is_hi;
    unique case (state)
      EMPTY: begin
        if (level != '0) begin
          dout_nxt  = hi_byte(mem[rptr]);
          hi_nxt    = 1'b1;
          vld_nxt   = 1'b1;
          state_nxt = SHOW_HI;
        end
      end
      SHOW_HI: begin
        if (rd_next) begin
          dout_nxt  = lo_byte(mem[rptr]);
          hi_nxt    = 1'b0;
          state_nxt = SHOW_LO;
        end
      end
      SHOW_LO: begin
        if (rd_next) begin
          if (level > LVL_W'(1)) begin
            dout_nxt  = hi_byte(mem[rptr_inc]);
            hi_nxt    = 1'b1;
            state_nxt = SHOW_HI;
          end else begin
            vld_nxt   = 1'b0;
            state_nxt = EMPTY;
          end
        end
      end
      default: begin
        vld_nxt   = 1'b0;
        state_nxt = EMPTY;
      end
    endcase
  end

  // ---- registered stage: control, pointers and presented byte ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      wptr       <= '0;
      rptr       <= '0;
      level      <= '0;
      full       <= 1'b0;
      data_out   <= 8'h00;
      byte_valid <= 1'b0;
      byte_is_hi <= 1'b0;
    end else begin
      state      <= state_nxt;
      level      <= level_nxt;
      full       <= (level_nxt == LVL_W'(DEPTH));
      data_out   <= dout_nxt;
      byte_valid <= vld_nxt;
      byte_is_hi <= hi_nxt;
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr_inc;
    end
  end

  // Sample storage carries no reset; occupancy is tracked by level and pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= y_in;
  end

`ifdef FIR_RD_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_fir_sample_reader.sv
// Self-checking bench for fir_sample_reader: directed plan steps plus random traffic
// checked each cycle against a queue-based reference model.
module tb_fir_sample_reader;
  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic signed [15:0] y_in;
  logic              y_valid, rd_next;
  logic [7:0]        data_out;
  logic              byte_valid, byte_is_hi, full;
  logic [LVL_W-1:0]  level;
`ifdef FIR_RD_OVF_EN
  logic              ovf_clr, ovf;
`endif

  fir_sample_reader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .y_in(y_in), .y_valid(y_valid), .rd_next(rd_next),
`ifdef FIR_RD_OVF_EN
    .ovf_clr(ovf_clr), .ovf(ovf),
`endif
    .data_out(data_out), .byte_valid(byte_valid), .byte_is_hi(byte_is_hi),
    .level(level), .full(full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of buffered words plus the byte currently shown.
  logic [15:0] q[$];
  logic [7:0]  m_dout;
  logic        m_vld, m_hi, m_ovf;

  task automatic model_reset();
    q.delete();
    m_dout = 8'h00; m_vld = 1'b0; m_hi = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic model_edge(input logic yv, input logic [15:0] y, input logic rd, input logic clr);
    int  n;
    logic consume_lo, accept;
    n = q.size();
    consume_lo = m_vld && !m_hi && rd;
    accept = yv && (n < DEPTH || consume_lo);
    if (!m_vld) begin
      if (n > 0) begin m_dout = q[0][15:8]; m_hi = 1'b1; m_vld = 1'b1; end
    end else if (m_hi) begin
      if (rd) begin m_dout = q[0][7:0]; m_hi = 1'b0; end
    end else if (rd) begin
      if (n > 1) begin m_dout = q[1][15:8]; m_hi = 1'b1; end
      else m_vld = 1'b0;
    end
    if (consume_lo) void'(q.pop_front());
    if (accept) q.push_back(y);
    if (yv && !accept) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".data_out"}, 32'(data_out), 32'(m_dout));
    chk({tag, ".byte_valid"}, 32'(byte_valid), 32'(m_vld));
    chk({tag, ".byte_is_hi"}, 32'(byte_is_hi), 32'(m_hi));
    chk({tag, ".level"}, 32'(level), 32'(q.size()));
    chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
`ifdef FIR_RD_OVF_EN
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
`endif
  endtask

  // Called at a negedge: drive inputs, let one rising edge pass, check at the next negedge.
  task automatic step(input string tag, input logic yv, input logic [15:0] y, input logic rd,
                      input logic clr = 1'b0);
    y_valid = yv; y_in = y; rd_next = rd;
`ifdef FIR_RD_OVF_EN
    ovf_clr = clr;
`endif
    @(posedge clk);
    model_edge(yv, y, rd, clr);
    @(negedge clk);
    y_valid = 1'b0; rd_next = 1'b0;
`ifdef FIR_RD_OVF_EN
    ovf_clr = 1'b0;
`endif
    chk_all(tag);
  endtask

  logic [7:0] seq [5];

  initial begin
    rst_n = 1'b0; y_in = '0; y_valid = 1'b0; rd_next = 1'b0;
`ifdef FIR_RD_OVF_EN
    ovf_clr = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    chk_all("reset");
    rst_n = 1'b1;

    // Single word appears two cycles after its strobe and then holds.
    step("a55a_push", 1'b1, 16'hA55A, 1'b0);
    chk("a55a_not_yet", 32'(byte_valid), 32'd0);
    step("a55a_show", 1'b0, 16'h0, 1'b0);
    chk("a55a_hi", 32'({byte_valid, byte_is_hi, data_out, level}), 32'({1'b1, 1'b1, 8'hA5, 3'd1}));
    for (int i = 0; i < 10; i++) step("a55a_hold", 1'b0, 16'h0, 1'b0);
    step("a55a_rd1", 1'b0, 16'h0, 1'b1);
    chk("a55a_lo", 32'({byte_valid, byte_is_hi, data_out}), 32'({1'b1, 1'b0, 8'h5A}));
    step("a55a_rd2", 1'b0, 16'h0, 1'b1);
    chk("a55a_done", 32'({byte_valid, level}), 32'({1'b0, 3'd0}));

    // Three words streamed back-to-back.
    step("w3_push1", 1'b1, 16'h1234, 1'b0);
    step("w3_push2", 1'b1, 16'hFF00, 1'b0);
    step("w3_push3", 1'b1, 16'h8001, 1'b0);
    chk("w3_first", 32'({byte_valid, data_out}), 32'({1'b1, 8'h12}));
    seq[0] = 8'h34; seq[1] = 8'hFF; seq[2] = 8'h00; seq[3] = 8'h80; seq[4] = 8'h01;
    for (int i = 0; i < 5; i++) begin
      step("w3_rd", 1'b0, 16'h0, 1'b1);
      chk("w3_seq", 32'({byte_valid, data_out}), 32'({1'b1, seq[i]}));
    end
    step("w3_rd_last", 1'b0, 16'h0, 1'b1);
    chk("w3_end", 32'(byte_valid), 32'd0);

    // Overflow: fifth word dropped.
    for (int i = 1; i <= 5; i++) step("ovf_push", 1'b1, 16'(i), 1'b0);
    chk("ovf_full", 32'({full, level}), 32'({1'b1, 3'd4}));
`ifdef FIR_RD_OVF_EN
    chk("ovf_set", 32'(ovf), 32'd1);
    step("ovf_hold", 1'b0, 16'h0, 1'b0);
    step("ovf_clr", 1'b0, 16'h0, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(ovf), 32'd0);
`endif

    // Full FIFO in SHOW_LO: push and pop together.
    step("fl_rd_hi", 1'b0, 16'h0, 1'b1);
    step("fl_pushpop", 1'b1, 16'hBEEF, 1'b1);
    chk("fl_next", 32'({level, byte_is_hi, data_out}), 32'({3'd4, 1'b1, 8'h00}));
    for (int i = 0; i < 9; i++) step("fl_drain", 1'b0, 16'h0, 1'b1);
    chk("fl_empty", 32'({byte_valid, level}), 32'({1'b0, 3'd0}));

    // Asynchronous reset while in SHOW_LO with three words held.
    for (int i = 0; i < 3; i++) step("rst_fill", 1'b1, 16'hC000 + 16'(i), 1'b0);
    step("rst_rd", 1'b0, 16'h0, 1'b1);
    chk("rst_pre", 32'({byte_valid, byte_is_hi, level}), 32'({1'b1, 1'b0, 3'd3}));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step("rst_idle_rd", 1'b0, 16'h0, 1'b1);
    step("rst_newpush", 1'b1, 16'h7E81, 1'b0);
    step("rst_newshow", 1'b0, 16'h0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 9) < 4), 16'($urandom), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fir_sample_reader.md
Name: fir_sample_reader

Overview:
- Sits downstream of the FIR filter and buffers its 16-bit output samples in a small FIFO.
- Hands the samples out one byte at a time, high byte then low byte, to an external reader on an 8-bit port.
- The reader advances through the bytes with a one-cycle strobe.
- Lets the top level expose FIR results on an 8-bit bus instead of spending 16 pins.

Parameters:
- DEPTH, 4: FIFO depth in 16-bit words. Must be a power of two and at least 2.
- LVL_W, $clog2(DEPTH)+1: width of the level output. Derived; do not override.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- y_in  input  16  FIR output sample, two's complement.
- y_valid  input  1  one-cycle strobe: y_in is a new sample this cycle.
- rd_next  input  1  one-cycle strobe from the reader: the current byte has been consumed.
- data_out  output  8  byte being presented, registered.
- byte_valid  output  1  data_out holds a valid byte.
- byte_is_hi  output  1  1 when data_out is the high byte [15:8]; 0 when it is the low byte [7:0].
- level  output  LVL_W  words held in the FIFO, including the word currently being presented.
- full  output  1  level == DEPTH.

Behaviour:
- Reset is asynchronous and active-low.
  - On reset: FIFO emptied, level=0, full=0, data_out=8'h00, byte_valid=0, byte_is_hi=0, state EMPTY.
  - Reset asserted mid-operation discards all buffered words and any partly read word.
- FIFO storage:
  - Circular buffer with write and read pointers of $clog2(DEPTH) bits each; pointers wrap modulo DEPTH.
  - level tracks occupancy separately, from 0 to DEPTH.
- Push: on y_valid, y_in is written if level<DEPTH, or if a pop happens in the same cycle.
  - Otherwise the sample is silently dropped; contents and level are unchanged.
- Pop: the head word is removed only when the reader consumes its low byte (see SHOW_LO).
- Push and pop in the same cycle: level is unchanged and both pointers advance, including when full.
- Presentation state machine:
  - EMPTY: byte_valid=0. If level>0 at the clock edge: data_out<=head[15:8], byte_is_hi<=1, byte_valid<=1, go to SHOW_HI.
    - A word pushed into an empty FIFO therefore appears on data_out 2 cycles after its y_valid edge.
  - SHOW_HI: on rd_next: data_out<=head[7:0], byte_is_hi<=0, go to SHOW_LO. Otherwise hold.
  - SHOW_LO: on rd_next, pop the head.
    - If a following word exists (level>1 before the pop): data_out<=next[15:8], byte_is_hi<=1, go to SHOW_HI. Back-to-back bytes, no gap.
    - If level==1 and y_valid is asserted that cycle: the new word is written and enters through EMPTY on the next cycle (one bubble cycle).
    - Else: byte_valid<=0, data_out holds its last value, go to EMPTY.
  - rd_next while byte_valid=0 is ignored.
- While a word is being presented (SHOW_HI, SHOW_LO), the head entry is never overwritten, even when full.
- level and full are registered and update on the same edge as the push/pop.

Optional Feature:
- Macro: FIR_RD_OVF_EN.
- Defined:
  - Adds output ovf (1 bit), a sticky flag set on the cycle after any dropped sample.
  - Adds input ovf_clr (1 bit, synchronous), which clears ovf.
  - ovf_clr and a drop in the same cycle: ovf stays 1 (set wins).
  - ovf resets to 0.
- Undefined: ovf and ovf_clr do not exist; drops are silent; all other behaviour is identical.

Test Plan:
- Reset, then y_valid with y_in=16'hA55A, no rd_next:
  - 2 cycles later: data_out=8'hA5, byte_is_hi=1, byte_valid=1, level=1.
  - Outputs hold for 10 cycles.
- From that state, rd_next pulses on two consecutive cycles:
  - data_out goes 8'hA5 -> 8'h5A -> byte_valid=0.
  - level ends at 0.
- Push 16'h1234, 16'hFF00, 16'h8001, then rd_next held for 6 cycles:
  - data_out sequence is 12,34,FF,00,80,01 with no gaps.
  - byte_valid drops on the following cycle.
- DEPTH=4: push 5 words 16'h0001..16'h0005 with no reads:
  - level=4, full=1; the 5th word is dropped.
  - Draining yields 0001..0004.
  - With FIR_RD_OVF_EN, ovf=1 until an ovf_clr pulse.
- Full FIFO in SHOW_LO: y_valid=1 and rd_next=1 in the same cycle:
  - level stays 4 and the new word is accepted.
  - The next byte presented is the high byte of the second-oldest word.
- Assert rst_n=0 asynchronously while in SHOW_LO with level=3:
  - Outputs go to their reset values immediately.
  - After release, rd_next pulses produce nothing until a new y_valid.
